// File: rtl/nff_delay.sv
// nff_delay: N-stage, WIDTH-bit register delay line with a shared enable and
// a synchronous active-high flush. N = 0 degenerates to a wire.
//
// Optional build macro:
//   NFF_ASSERT_EN - adds elaboration checks on N / WIDTH and a simulation
//                   assertion that a filled pipe never drives X/Z on out.
module nff_delay #(
  parameter int N     = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] inp,
  output logic [WIDTH-1:0] out
);

  if (N > 0) begin : g_pipe
    // Stage 0 is the entry stage; stage N-1 drives out directly.
    // NOTE: the stages carry a declaration initializer so a pipe whose reset
    // is tied low still starts at zero; the synchronous reset clears them too.
    logic [N-1:0][WIDTH-1:0] stage_q = '0;
    logic [N-1:0][WIDTH-1:0] stage_d;

    // Next-state shift: hold by default, shift one position when enabled.
    always_comb begin
      // NOTE: default assignment first so no path leaves stage_d unassigned
      // (which would infer a latch).
      stage_d = stage_q;
      if (enable) begin
        stage_d[0] = inp;
        for (int i = 1; i < N; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end
    end

    // State register: reset has priority over enable, so inp is not captured
    // on a reset edge.
    always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment so every stage samples the pre-edge
      // value of its neighbour.
      if (reset) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign out = stage_q[N-1];

  end else if (N == 0) begin : g_wire
    // Zero-latency build: clock, reset and enable have no effect.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, reset, enable};
    assign out         = inp;
  end

`ifdef NFF_ASSERT_EN
  if (N < 0) begin : g_bad_n
    $fatal(1, "nff_delay: N must be >= 0");
  end
  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "nff_delay: WIDTH must be >= 1");
  end

  // Count enabled edges since time zero or the last reset, saturating at N,
  // and remember whether reset was high on the previous edge.
  logic [31:0] fill_cnt_q   = '0;
  logic [31:0] fill_cnt_d;
  logic        reset_prev_q = 1'b0;

  // Next fill count: clear on reset, otherwise step on enabled edges.
  always_comb begin
    fill_cnt_d = fill_cnt_q;
    if (reset) begin
      fill_cnt_d = '0;
    end else if (enable && (fill_cnt_q < 32'(N))) begin
      fill_cnt_d = fill_cnt_q + 32'd1;
    end
  end

  // Fill counter and previous-reset registers.
  always_ff @(posedge clk) begin
    fill_cnt_q   <= fill_cnt_d;
    reset_prev_q <= reset;
  end

  // Once every stage has been written with real data, out must be known.
  a_out_known : assert property (
    @(posedge clk) (!reset_prev_q && (fill_cnt_q >= 32'(N))) |-> !$isunknown(out)
  ) else $error("nff_delay: out is X/Z on a filled pipe");
`endif

endmodule

// File: tb/tb_nff_delay.sv
// Self-checking bench for nff_delay. Several instances cover the documented
// scenarios; a randomized run compares against a history-queue reference:
// out equals the input captured N enabled edges ago since the last reset,
// or zero if fewer than N enabled edges have happened.
module tb_nff_delay;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Instance A: N=3, WIDTH=8
  logic       rst_a, en_a;
  logic [7:0] inp_a, out_a;
  nff_delay #(.N(3), .WIDTH(8)) u_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .inp(inp_a), .out(out_a)
  );

  // Instance B: N=4, WIDTH=8
  logic       rst_b, en_b;
  logic [7:0] inp_b, out_b;
  nff_delay #(.N(4), .WIDTH(8)) u_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .inp(inp_b), .out(out_b)
  );

  // Instance C: N=2, WIDTH=9, self-flushing from out[0]
  logic       rst_c, en_c;
  logic [8:0] inp_c, out_c;
  assign rst_c = out_c[0];
  nff_delay #(.N(2), .WIDTH(9)) u_c (
    .clk(clk), .reset(rst_c), .enable(en_c), .inp(inp_c), .out(out_c)
  );

  // Instance D: N=0, WIDTH=16 pass-through
  logic        rst_d, en_d;
  logic [15:0] inp_d, out_d;
  nff_delay #(.N(0), .WIDTH(16)) u_d (
    .clk(clk), .reset(rst_d), .enable(en_d), .inp(inp_d), .out(out_d)
  );

  // Instance E: N=5, WIDTH=12 for randomized traffic
  logic        rst_e, en_e;
  logic [11:0] inp_e, out_e;
  nff_delay #(.N(5), .WIDTH(12)) u_e (
    .clk(clk), .reset(rst_e), .enable(en_e), .inp(inp_e), .out(out_e)
  );

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: word captured n enabled edges ago, or zero if not yet filled.
  function automatic logic [15:0] ref_out(input logic [15:0] h[$], input int n);
    if (h.size() < n) return '0;
    return h[h.size() - n];
  endfunction

  task automatic test_reset();
    #1;
    if (out_a !== 8'h00) begin tests_failed++; $display("FAIL init_a: got %h want 00", out_a); end
    tests_run++;
    if (out_b !== 8'h00) begin tests_failed++; $display("FAIL init_b: got %h want 00", out_b); end
    tests_run++;
    if (out_c !== 9'h000) begin tests_failed++; $display("FAIL init_c: got %h want 000", out_c); end
    tests_run++;
    if (out_e !== 12'h000) begin tests_failed++; $display("FAIL init_e: got %h want 000", out_e); end
    tests_run++;
    // Load some data, then reset with enable high.
    en_a = 1'b1; en_b = 1'b1; en_e = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inp_a = 8'($urandom_range(1, 255));
      inp_b = 8'($urandom_range(1, 255));
      inp_e = 12'($urandom_range(1, 4095));
      tick();
    end
    rst_a = 1'b1; rst_b = 1'b1; rst_e = 1'b1;
    tick();
    if (out_a !== 8'h00) begin tests_failed++; $display("FAIL reset_a: got %h want 00", out_a); end
    tests_run++;
    if (out_b !== 8'h00) begin tests_failed++; $display("FAIL reset_b: got %h want 00", out_b); end
    tests_run++;
    if (out_e !== 12'h000) begin tests_failed++; $display("FAIL reset_e: got %h want 000", out_e); end
    tests_run++;
    rst_a = 1'b0; rst_b = 1'b0; rst_e = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_e = 1'b0;
    inp_a = '0; inp_b = '0; inp_e = '0;
  endtask

  task automatic test_basic();
    logic [7:0] stim [6];
    logic [7:0] exp  [6];
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
    exp  = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    en_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      inp_a = stim[i];
      tick();
      if (out_a !== exp[i]) begin
        tests_failed++;
        $display("FAIL basic_edge%0d: got %h want %h", i + 1, out_a, exp[i]);
      end
      tests_run++;
    end
  endtask

  task automatic test_enable_stall();
    logic [15:0] hist[$];
    logic [7:0]  prev;
    logic [7:0]  want;
    rst_a = 1'b1; en_a = 1'b1; inp_a = 8'hFF;
    tick();
    rst_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      en_a  = !(i == 6 || i == 7);
      inp_a = 8'hA1 + 8'(i);
      prev  = out_a;
      tick();
      if (en_a) hist.push_back(16'(inp_a));
      want = ref_out(hist, 3)[7:0];
      if (out_a !== want) begin
        tests_failed++;
        $display("FAIL stall_cycle%0d: got %h want %h", i, out_a, want);
      end
      tests_run++;
      if (!en_a) begin
        if (out_a !== prev) begin
          tests_failed++;
          $display("FAIL stall_hold%0d: got %h want %h", i, out_a, prev);
        end
        tests_run++;
      end
    end
    en_a = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] want;
    en_b = 1'b1; inp_b = 8'h5A;
    for (int i = 0; i < 4; i++) tick();
    if (out_b !== 8'h5A) begin tests_failed++; $display("FAIL midrst_full: got %h want 5a", out_b); end
    tests_run++;
    rst_b = 1'b1; inp_b = 8'h77;
    tick();
    if (out_b !== 8'h00) begin tests_failed++; $display("FAIL midrst_clear: got %h want 00", out_b); end
    tests_run++;
    rst_b = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      inp_b = 8'(k);
      tick();
      want = (k < 4) ? 8'h00 : 8'(k - 3);
      if (out_b !== want) begin
        tests_failed++;
        $display("FAIL midrst_after%0d: got %h want %h", k, out_b, want);
      end
      tests_run++;
    end
    en_b = 1'b0;
  endtask

  task automatic test_self_flush();
    logic [8:0] stim [5];
    logic [8:0] exp  [5];
    stim = '{9'h001, 9'h0F0, 9'h000, 9'h000, 9'h000};
    exp  = '{9'h000, 9'h001, 9'h000, 9'h000, 9'h000};
    en_c = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inp_c = stim[i];
      tick();
      if (out_c !== exp[i]) begin
        tests_failed++;
        $display("FAIL flush_edge%0d: got %h want %h", i + 1, out_c, exp[i]);
      end
      tests_run++;
    end
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 8; i++) begin
      inp_d = (i % 2 == 0) ? 16'hBEEF : 16'h1234;
      rst_d = 1'($urandom_range(1));
      en_d  = 1'($urandom_range(1));
      #3;
      if (out_d !== inp_d) begin
        tests_failed++;
        $display("FAIL passthru%0d: got %h want %h", i, out_d, inp_d);
      end
      tests_run++;
    end
  endtask

  task automatic test_random();
    logic [15:0] hist[$];
    logic [11:0] want;
    int          bad = 0;
    for (int i = 0; i < 300; i++) begin
      rst_e = (i == 0) || ($urandom_range(15) == 0);
      en_e  = ($urandom_range(3) != 0);
      inp_e = 12'($urandom);
      tick();
      if (rst_e)     hist.delete();
      else if (en_e) hist.push_back(16'(inp_e));
      if (hist.size() > 5) void'(hist.pop_front());
      want = ref_out(hist, 5)[11:0];
      if (out_e !== want) begin
        tests_failed++;
        bad++;
        if (bad <= 10) $display("FAIL random_cycle%0d: got %h want %h", i, out_e, want);
      end
      tests_run++;
    end
    rst_e = 1'b0; en_e = 1'b0;
  endtask

  initial begin
    rst_a = 1'b0; en_a = 1'b0; inp_a = '0;
    rst_b = 1'b0; en_b = 1'b0; inp_b = '0;
    en_c  = 1'b0; inp_c = '0;
    rst_d = 1'b0; en_d = 1'b0; inp_d = '0;
    rst_e = 1'b0; en_e = 1'b0; inp_e = '0;
    test_reset();
    test_basic();
    test_enable_stall();
    test_reset_mid();
    test_self_flush();
    test_passthrough();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
